// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer and the decoder that feeds it.
package muldiv_pkg;

    localparam int         XLEN_DEF      = 32;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } muldiv_mode_e;

    function automatic logic rs1_signed(muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic rs2_signed(muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage handshake between the decoder/pipeline (master) and the mul/div sequencer (slave).
interface muldiv_if #(
    parameter int XLEN = muldiv_pkg::XLEN_DEF
);
    logic            valid_in;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            flush;
    logic            stall;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output valid_in, funct3, rs1_val, rs2_val, flush,
        input  stall, result_valid, result
    );

    modport slave (
        input  valid_in, funct3, rs1_val, rs2_val, flush,
        output stall, result_valid, result
    );
endinterface

// File: rtl/muldiv_iter.sv
// One combinational step of the unsigned core: shift-add multiply or restoring divide.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  muldiv_mode_e      mode,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next
);
    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    // Multiply keeps the multiplier in the low half and shifts right; divide keeps
    // {rem, quo} and shifts left. The extra bit catches the add carry / subtract borrow.
    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        diff     = rem_sh - {1'b0, operand};
        acc_next = '0;
        if (mode == MODE_MUL)
            acc_next = {sum, acc[XLEN-1:1]};
        else if (!diff[XLEN])
            acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M sequencer: captures operands, iterates XLEN cycles while stalling EX, then
// presents one sign-corrected result. Divide-by-zero and signed overflow finish at once.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);
    localparam int              CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_in, op_q;
    muldiv_mode_e      mode;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q, acc_step, prod;
    logic [XLEN-1:0]   opnd_q, result_q, spec_res_q, spec_res, fix_res;
    logic [XLEN-1:0]   mag1, mag2, quo, rem;
    logic              neg_q, rem_neg_q, special_q;
    logic              s1, s2, div_zero, div_ovf, accept, stall, result_valid;

    assign op_in    = muldiv_op_e'(bus.funct3);
    assign s1       = rs1_signed(op_in) & bus.rs1_val[XLEN-1];
    assign s2       = rs2_signed(op_in) & bus.rs2_val[XLEN-1];
    assign mag1     = s1 ? -bus.rs1_val : bus.rs1_val;
    assign mag2     = s2 ? -bus.rs2_val : bus.rs2_val;
    assign div_zero = op_in[2] && (bus.rs2_val == '0);
    assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
                      (bus.rs1_val == MIN_NEG) && (bus.rs2_val == '1);
    assign accept   = (state_q == IDLE) && bus.valid_in && !bus.flush;
    assign mode     = op_q[2] ? MODE_DIV : MODE_MUL;

    // REM/REMU by zero hand back the dividend; overflowing DIV returns rs1 itself.
    always_comb begin
        spec_res = '0;
        if (div_zero)
            spec_res = op_in[1] ? bus.rs1_val : '1;
        else if (op_in == OP_DIV)
            spec_res = MIN_NEG;
    end

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .mode     (mode),
        .acc      (acc_q),
        .operand  (opnd_q),
        .acc_next (acc_step)
    );

    always_comb begin
        prod    = neg_q ? -acc_q : acc_q;
        quo     = acc_q[XLEN-1:0];
        rem     = acc_q[2*XLEN-1:XLEN];
        fix_res = '0;
        case (op_q)
            OP_MUL:                        fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
            OP_DIV:                        fix_res = neg_q ? -quo : quo;
            OP_DIVU:                       fix_res = quo;
            OP_REM:                        fix_res = rem_neg_q ? -rem : rem;
            OP_REMU:                       fix_res = rem;
            default:                       fix_res = '0;
        endcase
        if (special_q)
            fix_res = spec_res_q;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        stall        = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                stall   = 1'b1;
                state_d = (div_zero || div_ovf) ? DONE : BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q == CW'(XLEN-1)) state_d = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d      = IDLE;
            result_valid = 1'b0;
        end
        if (reset) begin
            stall        = 1'b0;
            result_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= OP_MUL;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
        end else begin
            if (accept) begin
                op_q       <= op_in;
                cnt_q      <= '0;
                acc_q      <= {{XLEN{1'b0}}, mag1};
                opnd_q     <= mag2;
                neg_q      <= s1 ^ s2;
                rem_neg_q  <= s1;
                special_q  <= div_zero || div_ovf;
                spec_res_q <= spec_res;
            end else if (state_q == BUSY && !bus.flush) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q + 1'b1;
            end
            if (result_valid)
                result_q <= fix_res;
        end
    end

    assign bus.stall        = stall;
    assign bus.result_valid = result_valid;
    assign bus.result       = reset ? '0 : (result_valid ? fix_res : result_q);
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed RV32M cases, random ops against an
// arithmetic reference model, flush/reset interruption and back-to-back issue.
module tb_muldiv_ctrl;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] last_res = '0;

    muldiv_if #(.XLEN(32)) bus();

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] exp;
        int          lat;
        exp = ref_model(op, a, b);
        lat = latency(op, a, b);
        @(posedge clk); #1;
        bus.valid_in = 1'b1; bus.funct3 = op; bus.rs1_val = a; bus.rs2_val = b;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            n_checks++;
            if (bus.stall !== (k < lat)) begin
                n_fail++;
                $display("FAIL %s stall@T+%0d: got %b expected %b", nm, k, bus.stall, k < lat);
            end
            n_checks++;
            if (bus.result_valid !== (k == lat)) begin
                n_fail++;
                $display("FAIL %s result_valid@T+%0d: got %b expected %b", nm, k,
                         bus.result_valid, k == lat);
            end
            if (k == lat) begin
                n_checks++;
                if (bus.result !== exp) begin
                    n_fail++;
                    $display("FAIL %s result op=%0d a=%h b=%h: got %h expected %h",
                             nm, op, a, b, bus.result, exp);
                end
            end
        end
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.result_valid !== 1'b0 || bus.stall !== 1'b0 || bus.result !== exp) begin
            n_fail++;
            $display("FAIL %s idle-after: got rv=%b stall=%b result=%h expected 0 0 %h",
                     nm, bus.result_valid, bus.stall, bus.result, exp);
        end
        last_res = exp;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 1'b0 || bus.result_valid !== 1'b0 || bus.result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got stall=%b rv=%b result=%h expected 0 0 0",
                     bus.stall, bus.result_valid, bus.result);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 1'b0 || bus.result_valid !== 1'b0 || bus.result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_release: got stall=%b rv=%b result=%h expected 0 0 0",
                     bus.stall, bus.result_valid, bus.result);
        end
    endtask

    task automatic test_directed();
        run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_m7_2", 3'd5, 32'hFFFF_FFF9, 32'd2);
    endtask

    task automatic test_special();
        run_op("divu_by0", 3'd5, 32'd5, 32'd0);
        run_op("remu_by0", 3'd7, 32'd5, 32'd0);
        run_op("div_ovf", 3'd4, MIN_NEG, 32'hFFFF_FFFF);
        run_op("rem_ovf", 3'd6, MIN_NEG, 32'hFFFF_FFFF);
        run_op("div_by0", 3'd4, 32'h1234_5678, 32'd0);
        run_op("rem_by0", 3'd6, 32'hF000_0001, 32'd0);
    endtask

    task automatic test_flush_idle();
        @(posedge clk); #1;
        bus.valid_in = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd5;
        bus.rs1_val = 32'd9; bus.rs2_val = 32'd0;
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle stall: got %b expected 0", bus.stall);
        end
        @(posedge clk); #1;
        bus.valid_in = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.result_valid !== 1'b0 || bus.stall !== 1'b0 || bus.result !== last_res) begin
            n_fail++;
            $display("FAIL flush_idle after: got rv=%b stall=%b result=%h expected 0 0 %h",
                     bus.result_valid, bus.stall, bus.result, last_res);
        end
    endtask

    task automatic test_interrupt(input bit use_reset);
        string nm;
        nm = use_reset ? "reset_mid" : "flush_mid";
        @(posedge clk); #1;
        bus.valid_in = 1'b1; bus.funct3 = 3'd0; bus.rs1_val = $urandom; bus.rs2_val = $urandom;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.stall !== 1'b1 || bus.result_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s pre@T+%0d: got stall=%b rv=%b expected 1 0",
                         nm, k, bus.stall, bus.result_valid);
            end
            @(posedge clk); #1;
        end
        if (use_reset) reset = 1'b1;
        else           bus.flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.result_valid !== 1'b0 || bus.stall !== !use_reset) begin
            n_fail++;
            $display("FAIL %s @T+10: got stall=%b rv=%b expected %b 0",
                     nm, bus.stall, bus.result_valid, !use_reset);
        end
        @(posedge clk); #1;
        reset = 1'b0; bus.flush = 1'b0; bus.valid_in = 1'b0;
        if (use_reset) last_res = '0;
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 1'b0 || bus.result_valid !== 1'b0 || bus.result !== last_res) begin
            n_fail++;
            $display("FAIL %s @T+11: got stall=%b rv=%b result=%h expected 0 0 %h",
                     nm, bus.stall, bus.result_valid, bus.result, last_res);
        end
        run_op({nm, "_mul3x4"}, 3'd0, 32'd3, 32'd4);
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        @(posedge clk); #1;
        bus.valid_in = 1'b1; bus.funct3 = 3'd5; bus.rs1_val = 32'd100; bus.rs2_val = 32'd7;
        for (int k = 0; k <= 70; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (k == 34) bus.funct3 = 3'd7;
                if (k == 68) bus.valid_in = 1'b0;
            end
            @(negedge clk);
            if (bus.result_valid === 1'b1) pulses++;
            n_checks++;
            if (bus.stall !== ((k < 33) || (k >= 34 && k < 67))) begin
                n_fail++;
                $display("FAIL b2b stall@T+%0d: got %b", k, bus.stall);
            end
            if (k == 33 || k == 67) begin
                n_checks++;
                if (bus.result_valid !== 1'b1 || bus.result !== ((k == 33) ? 32'd14 : 32'd2)) begin
                    n_fail++;
                    $display("FAIL b2b result@T+%0d: got rv=%b result=%h expected 1 %h",
                             k, bus.result_valid, bus.result, (k == 33) ? 32'd14 : 32'd2);
                end
            end
        end
        n_checks++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL b2b pulse_count: got %0d expected 2", pulses);
        end
        last_res = 32'd2;
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        int          sel;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 15);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 15));
            if (sel == 3) a = 32'($urandom_range(0, 200));
            run_op($sformatf("rand%0d", i), op, a, b);
        end
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.flush    = 1'b0;
        bus.funct3   = 3'd0;
        bus.rs1_val  = '0;
        bus.rs2_val  = '0;
        test_reset();
        test_directed();
        test_special();
        test_flush_idle();
        test_interrupt(1'b0);
        test_interrupt(1'b1);
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the RV32M multiply/divide extension in the EX stage. When the decoder flags an R-type instruction with funct7 = 0000001, this block captures both operands and runs an iterative shift-add multiply or shift-subtract divide over XLEN cycles. While it runs, it stalls the pipeline. It then presents one result for EX→MEM writeback (reg_write_ctrl = 0 path). Divide-by-zero and signed-overflow cases finish in a single cycle.

## Interface
- XLEN, 32, operand/result width; iteration count equals XLEN.
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high.
- valid_in  in  1  EX holds an M-extension op (OP_R3 & funct7 = 0000001); held until released by stall = 0.
- funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  in  XLEN  dividend / multiplicand.
- rs2_val  in  XLEN  divisor / multiplier.
- flush  in  1  kill the in-flight op (branch/jump redirect).
- stall  out  1  freeze IF/ID/EX; combinational.
- result_valid  out  1  one-cycle pulse; result is valid this cycle.
- result  out  XLEN  final value; held until the next accept.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - valid_in & ~flush with a normal op → latch funct3, operand magnitudes and sign flags; clear counter; go to BUSY.
  - valid_in & ~flush with a special case → load the special result; go directly to DONE.
- BUSY: one iteration per cycle; counter counts 0..XLEN-1; at XLEN-1 go to DONE.
- DONE: apply sign fixup and drive result; result_valid = 1; return to IDLE. DONE never samples valid_in, so the same instruction cannot relaunch.
- stall = (IDLE & valid_in & ~flush) | BUSY. stall is 0 in DONE and during reset.
- Signed handling (core is always unsigned):
  - MULH: both operands signed.
  - MULHSU: rs1 signed only.
  - DIV/REM: both signed.
  - Negative operands are converted to two's-complement magnitude.
  - Product negated if the operand signs differ.
  - Quotient negated if the signs differ; remainder takes the dividend's sign.
- Multiply: 2·XLEN accumulator. MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- Divide: restoring algorithm. Each step shifts {rem, quo} left by 1, subtracts the divisor if rem ≥ divisor, and sets the quotient bit.
- Special cases (single cycle):
  - Divisor = 0: DIV/DIVU → all ones; REM/REMU → rs1.
  - DIV with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: → 0x80000000.
  - REM with the same operands: → 0.
- flush has priority over everything except reset. From any state, go to IDLE next cycle with no result_valid; result keeps its old value.

## Timing
- Normal op accepted at cycle T:
  - stall high T..T+XLEN (T..T+32).
  - DONE and result_valid at T+XLEN+1 (T+33), with stall low that cycle.
  - Pipeline advances at the end of T+33.
  - A back-to-back op is seen in IDLE at T+34.
- Special case accepted at T: stall high at T; result_valid at T+1.
- flush at cycle F while BUSY: stall low from F+1; no result_valid.
- flush together with valid_in in IDLE: no accept, stall 0.
- Reset values:
  - state = IDLE, counter = 0.
  - result = 0, result_valid = 0, stall = 0.
  - All internal operand/accumulator registers = 0.
- Reset mid-op behaves like flush and additionally clears result.

## Structure
- Shared package muldiv_pkg holds:
  - XLEN_DEF = 32.
  - FUNCT7_MULDIV = 7'b0000001.
  - The funct3 enum muldiv_op_e.
  - The state enum muldiv_state_e.
- The decoder/control unit imports FUNCT7_MULDIV from the same package to generate valid_in.
- One sub-module, muldiv_iter:
  - Purely combinational single step: inputs mode, accumulator, operand; output next accumulator.
  - muldiv_ctrl owns the FSM, counter, sign fixup, special-case detection and registers.

## Test plan
- MUL rs1 = 7, rs2 = 0xFFFFFFFD, valid at T → stall high T..T+32; result_valid at T+33 with result 0xFFFFFFEB.
- rs1 = rs2 = 0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
  - Each completes at T+33.
- rs1 = 0xFFFFFFF9 (-7), rs2 = 2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU → 0x7FFFFFFC.
- Special cases, each with result_valid at T+1 and stall high only at T:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Interrupt mid-op:
  - flush at T+10 → stall 0 from T+11, no result_valid, result unchanged.
  - A following MUL 3·4 accepted at T+12 → result 12 at T+45.
  - Repeat with reset at T+10 → additionally result = 0.
- Back-to-back: DIVU 100/7 then REMU 100/7 with valid_in held continuously.
  - Results 14 at T+33 and 2 at T+67.
  - Exactly two result_valid pulses.
